muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage: shift-add multiply and
// restoring divide, one bit per cycle, with stall/flush handshake to the hazard unit.
module muldiv_unit #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             stall,
   input  logic             flush,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef logic [WIDTH-1:0] word_t;
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b001;
   localparam logic [2:0] OP_DIVU = 3'b010;
   localparam logic [2:0] OP_REM  = 3'b011;
   localparam logic [2:0] OP_REMU = 3'b100;
   localparam word_t      MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2:0]         op_reg;
   word_t              a_reg;       // original dividend, needed by the special cases
   word_t              x_reg;       // MUL: shifting multiplicand; DIV: dividend/quotient
   word_t              y_reg;       // MUL: shifting multiplier;   DIV: divisor magnitude
   word_t              acc_reg;     // MUL: partial product;       DIV: partial remainder
   word_t              result_reg;
   logic               neg_q_reg, neg_r_reg, dz_reg, ovf_reg;

   // Operand decode on the incoming request
   logic  op_legal, in_signed;
   word_t a_mag, b_mag;

   assign op_legal  = (op <= OP_REMU);
   assign in_signed = (op == OP_DIV) || (op == OP_REM);
   assign a_mag     = (in_signed && a[WIDTH-1]) ? word_t'(-a) : a;
   assign b_mag     = (in_signed && b[WIDTH-1]) ? word_t'(-b) : b;

   // Iteration datapath on latched state
   logic         iter_done, is_quot;
   logic [WIDTH:0] div_shift, div_diff;
   word_t        mul_add, q_final, r_final;

   assign iter_done = (cnt_reg == CNT_W'(WIDTH));
   assign is_quot   = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
   assign mul_add   = acc_reg + (y_reg[0] ? x_reg : '0);
   assign div_shift = {acc_reg, x_reg[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, y_reg};
   assign q_final   = neg_q_reg ? word_t'(-x_reg) : x_reg;
   assign r_final   = neg_r_reg ? word_t'(-acc_reg) : acc_reg;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (valid) begin
                  if (!op_legal)          state_next = S_DONE;
                  else if (op == OP_MUL)  state_next = S_MUL;
                  else                    state_next = S_DIV;
               end
            end
            S_MUL:  if (iter_done) state_next = S_DONE;
            S_DIV:  if (dz_reg || ovf_reg || iter_done) state_next = S_DONE;
            S_DONE: if (!stall) state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of registered state
   always_comb begin
      done   = (state_reg == S_DONE);
      busy   = (state_reg != S_IDLE);
      result = result_reg;
   end

   // Datapath
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg    <= '0;
         op_reg     <= '0;
         a_reg      <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dz_reg     <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (valid && !flush) begin
                  op_reg    <= op;
                  a_reg     <= a;
                  cnt_reg   <= '0;
                  acc_reg   <= '0;
                  neg_q_reg <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_reg <= in_signed && a[WIDTH-1];
                  dz_reg    <= (b == '0);
                  ovf_reg   <= in_signed && (a == MOST_NEG) && (b == '1);
                  if (op == OP_MUL) begin
                     x_reg <= a;
                     y_reg <= b;
                  end else begin
                     x_reg <= a_mag;
                     y_reg <= b_mag;
                  end
                  if (!op_legal) result_reg <= '0;
               end
            end
            S_MUL: begin
               if (!flush) begin
                  if (!iter_done) begin
                     acc_reg <= mul_add;
                     x_reg   <= x_reg << 1;
                     y_reg   <= y_reg >> 1;
                     cnt_reg <= cnt_reg + 1'b1;
                  end else begin
                     result_reg <= acc_reg;
                  end
               end
            end
            S_DIV: begin
               if (!flush) begin
                  if (dz_reg) begin
                     result_reg <= is_quot ? '1 : a_reg;
                  end else if (ovf_reg) begin
                     result_reg <= is_quot ? a_reg : '0;
                  end else if (!iter_done) begin
                     // A clear top bit means the trial subtraction did not borrow
                     if (!div_diff[WIDTH]) begin
                        acc_reg <= div_diff[WIDTH-1:0];
                        x_reg   <= {x_reg[WIDTH-2:0], 1'b1};
                     end else begin
                        acc_reg <= div_shift[WIDTH-1:0];
                        x_reg   <= {x_reg[WIDTH-2:0], 1'b0};
                     end
                     cnt_reg <= cnt_reg + 1'b1;
                  end else begin
                     result_reg <= is_quot ? q_final : r_final;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results and latencies,
// a negedge monitor pops and compares on each rising done.
module tb_muldiv_unit;

   localparam int W = 64;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b001;
   localparam logic [2:0] OP_DIVU = 3'b010;
   localparam logic [2:0] OP_REM  = 3'b011;
   localparam logic [2:0] OP_REMU = 3'b100;

   logic         clk, resetn, valid, stall, flush;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         done, busy;
   logic [W-1:0] result;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   neg_cnt  = 0;
   logic done_prev = 1'b0;
   logic pend_idle = 1'b0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .valid  (valid),
      .op     (op),
      .a      (a),
      .b      (b),
      .stall  (stall),
      .flush  (flush),
      .done   (done),
      .busy   (busy),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%016h required 0x%016h", name, act, req);
      end
   endtask

   // Monitor: latency counted in negedges after the accept edge
   always @(negedge clk) begin
      exp_t e;
      neg_cnt++;
      if (pend_idle) begin
         check("idle_after_done", {62'd0, busy, done}, '0);
         pend_idle = 1'b0;
      end
      if (resetn && done && !done_prev) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done=1 result=0x%016h required done=0", result);
         end else begin
            e = sb.pop_front();
            check(e.name, result, e.res);
            check({e.name, "_latency"}, W'(neg_cnt - e.acc - 1), W'(e.lat));
            if (!stall) pend_idle = 1'b1;
         end
      end
      done_prev = done;
   end

   task automatic drain();
      bit ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !busy && !done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         $display("FAIL drain_timeout: got pending=%0d busy=%0b required pending=0 busy=0", sb.size(), busy);
         sb.delete();
      end
   endtask

   task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] exp_res, input int lat);
      exp_t e;
      @(posedge clk);
      #1;
      valid = 1'b1; op = o; a = xa; b = xb;
      @(posedge clk);
      e.name = name; e.res = exp_res; e.lat = lat; e.acc = neg_cnt;
      sb.push_back(e);
      #1;
      // Scramble operands right after accept; the result must not depend on them
      valid = 1'b0; op = 3'b111; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got_done;
      resetn = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0; stall = 1'b0; flush = 1'b0;
      #1 resetn = 1'b0;
      #1;
      check("reset_done",   {63'd0, done}, '0);
      check("reset_busy",   {63'd0, busy}, '0);
      check("reset_result", result, '0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      issue("mul_7x6",     OP_MUL,  64'd7, 64'd6, 64'd42, 65);
      issue("div_m7_2",    OP_DIV,  -64'sd7, 64'd2, -64'sd3, 65);
      issue("rem_m7_2",    OP_REM,  -64'sd7, 64'd2, -64'sd1, 65);
      issue("divu_7_2",    OP_DIVU, 64'd7, 64'd2, 64'd3, 65);
      issue("remu_7_2",    OP_REMU, 64'd7, 64'd2, 64'd1, 65);
      issue("div_7_m2",    OP_DIV,  64'd7, -64'sd2, -64'sd3, 65);
      issue("rem_7_m2",    OP_REM,  64'd7, -64'sd2, 64'd1, 65);
      issue("mul_m3x5",    OP_MUL,  -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);
      issue("mul_wide",    OP_MUL,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 65);
      issue("divu_max_3",  OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65);
      issue("remu_100_7",  OP_REMU, 64'd100, 64'd7, 64'd2, 65);
      issue("divu_5_0",    OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      issue("remu_5_0",    OP_REMU, 64'd5, 64'd0, 64'd5, 1);
      issue("div_m5_0",    OP_DIV,  -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      issue("rem_m5_0",    OP_REM,  -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
      issue("div_ovf",     OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      issue("rem_ovf",     OP_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      issue("illegal_op",  3'b101,  64'd9, 64'd9, 64'd0, 0);

      // flush together with valid in IDLE: nothing accepted
      @(posedge clk);
      #1 valid = 1'b1; flush = 1'b1; op = OP_MUL; a = 64'd3; b = 64'd3;
      @(posedge clk);
      #1 valid = 1'b0; flush = 1'b0;
      check("flush_wins_busy", {63'd0, busy}, '0);

      // flush in the 10th cycle of a DIV
      @(posedge clk);
      #1 valid = 1'b1; op = OP_DIV; a = 64'd100; b = 64'd7;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_busy", {63'd0, busy}, '0);
      check("flush_done", {63'd0, done}, '0);
      repeat (80) @(posedge clk);
      issue("div_after_flush", OP_DIV, 64'd100, 64'd7, 64'd14, 65);

      // stall held in DONE
      stall = 1'b1;
      @(posedge clk);
      #1 valid = 1'b1; op = OP_MUL; a = 64'd9; b = 64'd9;
      @(posedge clk);
      begin
         exp_t e;
         e.name = "mul_stalled"; e.res = 64'd81; e.lat = 65; e.acc = neg_cnt;
         sb.push_back(e);
      end
      #1 valid = 1'b0; a = '1; b = '1;
      got_done = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (done) begin
            got_done = 1'b1;
            break;
         end
      end
      check("stall_reached_done", {63'd0, got_done}, 64'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_hold_done", {63'd0, done}, 64'd1);
         check("stall_hold_result", result, 64'd81);
      end
      #1 stall = 1'b0;
      @(posedge clk);
      #1;
      check("stall_release_busy", {63'd0, busy}, '0);
      check("stall_release_done", {63'd0, done}, '0);

      // asynchronous reset mid-MUL
      @(posedge clk);
      #1 valid = 1'b1; op = OP_MUL; a = 64'd11; b = 64'd13;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (20) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      check("rst_mid_done",   {63'd0, done}, '0);
      check("rst_mid_busy",   {63'd0, busy}, '0);
      check("rst_mid_result", result, '0);
      @(posedge clk);
      #1 resetn = 1'b1;
      issue("mul_after_reset", OP_MUL, 64'd7, 64'd6, 64'd42, 65);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
